// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch buffer: default widths, the
// fetch state machine encoding and the FIFO entry layout.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT  = 10;
  localparam int INSTR_W_DEFAULT = 32;

  // SKIP swallows the one stale sequential fetch that follows a Refetch.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SKIP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0]  pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle between the PC / instruction memory / decode and the fetch buffer.
// slave is the fetch buffer's view, master is the surrounding pipeline's view.
interface instr_fetch_buffer_if #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0]      Address;
  logic                   Flush;
  logic [ADDR_W-1:0]      Imem_Addr;
  logic                   Imem_En;
  logic [INSTR_W-1:0]     Imem_Data;
  // Decode handshake: a word transfers on a cycle where Instr_Valid and
  // Instr_Ready are both high; Instr/Instr_PC hold while valid and not ready.
  logic [INSTR_W-1:0]     Instr;
  logic [ADDR_W-1:0]      Instr_PC;
  logic                   Instr_Valid;
  logic                   Instr_Ready;
  logic                   Refetch;
  logic [ADDR_W-1:0]      Refetch_Addr;
  fetch_state_e           state_dbg;
  logic [$clog2(DEPTH):0] count_dbg;

  modport slave (
    input  Address, Flush, Imem_Data, Instr_Ready,
    output Imem_Addr, Imem_En, Instr, Instr_PC, Instr_Valid,
           Refetch, Refetch_Addr, state_dbg, count_dbg
  );

  modport master (
    output Address, Flush, Imem_Data, Instr_Ready,
    input  Imem_Addr, Imem_En, Instr, Instr_PC, Instr_Valid,
           Refetch, Refetch_Addr, state_dbg, count_dbg
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding tagged fetch words; clear dominates push and pop.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_pkg::fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[PW:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: S1 register, overflow re-steer FSM and decode queue.
// Optional feature macro: FETCH_BYPASS_EN (empty-FIFO bypass to decode).
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
) (
  input logic                clk,
  input logic                Reset_n,
  instr_fetch_buffer_if.slave bus
);
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic                   s1_valid;
  logic [ADDR_W-1:0]      s1_pc;
  fetch_state_e           state;
  logic                   s1_ok;
  logic                   pop;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  entry_t                 wr_entry;
  entry_t                 rd_entry;

  assign bus.Imem_Addr = bus.Address;
  assign bus.Imem_En   = Reset_n;

  // The word in S1 is only usable when it was not fetched past a redirect.
  assign s1_ok    = s1_valid && (state == RUN) && !bus.Flush;
  assign wr_entry = '{pc: s1_pc, instr: bus.Imem_Data};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass          = fifo_empty && s1_ok;
  assign bus.Instr_Valid = !fifo_empty || bypass;
  assign bus.Instr       = bypass ? bus.Imem_Data : rd_entry.instr;
  assign bus.Instr_PC    = bypass ? s1_pc : rd_entry.pc;
  assign pop             = bus.Instr_Valid && bus.Instr_Ready;
  assign fifo_pop        = pop && !fifo_empty;
  assign fifo_push       = s1_ok && (!fifo_full || pop) && !(bypass && bus.Instr_Ready);
`else
  assign bus.Instr_Valid = !fifo_empty;
  assign bus.Instr       = rd_entry.instr;
  assign bus.Instr_PC    = rd_entry.pc;
  assign pop             = bus.Instr_Valid && bus.Instr_Ready;
  assign fifo_pop        = pop;
  assign fifo_push       = s1_ok && (!fifo_full || pop);
`endif

  assign overflow         = s1_ok && fifo_full && !pop;
  assign bus.Refetch      = overflow;
  assign bus.Refetch_Addr = overflow ? s1_pc : '0;
  assign bus.state_dbg    = state;
  assign bus.count_dbg    = fifo_count;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
    end else begin
      s1_valid <= !bus.Flush;
      s1_pc    <= bus.Address;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RUN;
    end else if (bus.Flush) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= overflow ? SKIP : RUN;
        SKIP:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (Reset_n),
    .clear (bus.Flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: PC and memory models, expected-PC
// queue scoreboard and per-cycle checks of overflow, flush and reset.
module tb_instr_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic Reset_n;

  instr_fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];

  logic               o_valid;
  logic [ADDR_W-1:0]  o_pc;
  logic [INSTR_W-1:0] o_instr;
  logic               o_ref;
  logic [ADDR_W-1:0]  o_ref_addr;
  fetch_state_e       o_state;
  logic [31:0]        o_count;
  logic [ADDR_W-1:0]  o_maddr;
  logic               o_men;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs held from just after the rising edge, outputs sampled
  // at the falling edge, then PC and memory advance just after the next edge.
  task automatic run_cycle(input logic rdy, input logic fl, input logic [ADDR_W-1:0] tgt);
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] e;
    bus.Instr_Ready = rdy;
    bus.Flush       = fl;
    @(negedge clk);
    o_valid    = bus.Instr_Valid;
    o_pc       = bus.Instr_PC;
    o_instr    = bus.Instr;
    o_ref      = bus.Refetch;
    o_ref_addr = bus.Refetch_Addr;
    o_state    = bus.state_dbg;
    o_count    = 32'(bus.count_dbg);
    o_maddr    = bus.Imem_Addr;
    o_men      = bus.Imem_En;
    if (o_valid && rdy) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(o_pc), 32'(e));
        check("sb_instr", o_instr, 32'(e) + 32'h100);
      end
    end
    if (fl)         nxt = tgt;
    else if (o_ref) nxt = o_ref_addr;
    else            nxt = bus.Address + 1'b1;
    @(posedge clk);
    #1;
    bus.Imem_Data = 32'(o_maddr) + 32'h100;
    bus.Address   = nxt;
    bus.Flush     = 1'b0;
  endtask

  task automatic do_reset(input logic check_rst);
    Reset_n         = 1'b0;
    bus.Address     = '0;
    bus.Flush       = 1'b0;
    bus.Instr_Ready = 1'b0;
    bus.Imem_Data   = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_rst) begin
      check("rst_valid", 32'(bus.Instr_Valid), 32'd0);
      check("rst_refetch", 32'(bus.Refetch), 32'd0);
      check("rst_imem_en", 32'(bus.Imem_En), 32'd0);
      check("rst_instr", bus.Instr, 32'd0);
      check("rst_pc", 32'(bus.Instr_PC), 32'd0);
      check("rst_ref_addr", 32'(bus.Refetch_Addr), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'(RUN));
      check("rst_count", 32'(bus.count_dbg), 32'd0);
    end
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    // Basic streaming with decode always ready.
    do_reset(1'b1);
    for (int i = 0; i <= 7 - LAT; i++) exp_q.push_back(ADDR_W'(i));
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b1, 1'b0, '0);
      if (c == LAT - 1) check("a_valid_early", 32'(o_valid), 32'd0);
      if (c == LAT)     check("a_valid_first", 32'(o_valid), 32'd1);
      if (c == 3) begin
        check("a_imem_addr", 32'(o_maddr), 32'd3);
        check("a_imem_en", 32'(o_men), 32'd1);
      end
    end
    check("a_drain", 32'(exp_q.size()), 32'd0);

    // Decode stalls six cycles: overflow, Refetch to 4, stale 5 skipped.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_W'(i));
    for (int c = 0; c < 14; c++) begin
      run_cycle(c >= 6, 1'b0, '0);
      if (c == 4) begin
        check("b_hold_pc", 32'(o_pc), 32'd0);
        check("b_hold_instr", o_instr, 32'h100);
        check("b_hold_valid", 32'(o_valid), 32'd1);
      end
      if (c == 5) begin
        check("b_full_count", o_count, 32'd4);
        check("b_refetch", 32'(o_ref), 32'd1);
        check("b_refetch_addr", 32'(o_ref_addr), 32'd4);
        check("b_state_run", 32'(o_state), 32'(RUN));
      end
      if (c == 6) begin
        check("b_state_skip", 32'(o_state), 32'(SKIP));
        check("b_skip_norefetch", 32'(o_ref), 32'd0);
      end
      if (c == 7) begin
        check("b_state_back", 32'(o_state), 32'(RUN));
        check("b_replay_norefetch", 32'(o_ref), 32'd0);
      end
    end
    check("b_drain", 32'(exp_q.size()), 32'd0);

    // Flush while Address=7 with words queued; PC jumps to 0x20.
    do_reset(1'b0);
    for (int i = 0; i <= 4 - LAT; i++) exp_q.push_back(ADDR_W'(i));
    for (int i = 0; i <= 4 - LAT; i++) exp_q.push_back(ADDR_W'(32'h20 + i));
    for (int c = 0; c < 13; c++) begin
      run_cycle(!(c >= 5 && c <= 7), c == 7, ADDR_W'(32'h20));
      if (c == 7) begin
        check("c_flush_addr", 32'(o_maddr), 32'd7);
        check("c_flush_norefetch", 32'(o_ref), 32'd0);
      end
      if (c == 8) begin
        check("c_valid_after_flush", 32'(o_valid), 32'd0);
        check("c_count_cleared", o_count, 32'd0);
      end
      if (c == 7 + LAT) check("c_valid_gap", 32'(o_valid), 32'd0);
      if (c == 8 + LAT) check("c_first_target", 32'(o_pc), 32'h20);
    end
    check("c_drain", 32'(exp_q.size()), 32'd0);

    // Flush on the same cycle overflow would have fired; target 0x40.
    do_reset(1'b0);
    for (int i = 0; i <= 4 - LAT; i++) exp_q.push_back(ADDR_W'(32'h40 + i));
    for (int c = 0; c < 11; c++) begin
      run_cycle(c >= 6, c == 5, ADDR_W'(32'h40));
      if (c == 5) begin
        check("d_full_count", o_count, 32'd4);
        check("d_flush_norefetch", 32'(o_ref), 32'd0);
      end
      if (c == 6) begin
        check("d_state_run", 32'(o_state), 32'(RUN));
        check("d_count_cleared", o_count, 32'd0);
        check("d_valid_low", 32'(o_valid), 32'd0);
      end
    end
    check("d_drain", 32'(exp_q.size()), 32'd0);

    // Full FIFO with simultaneous pop and push.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(ADDR_W'(i));
    for (int c = 0; c < 11; c++) begin
      run_cycle(c >= 5, 1'b0, '0);
      if (c == 5) begin
        check("e_full_count", o_count, 32'd4);
        check("e_pushpop_norefetch", 32'(o_ref), 32'd0);
      end
      if (c == 6) begin
        check("e_count_held", o_count, 32'd4);
        check("e_norefetch_next", 32'(o_ref), 32'd0);
        check("e_order_pc", 32'(o_pc), 32'd1);
      end
    end
    check("e_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-stream with three words queued.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0, '0);
    check("f_pre_count", 32'(bus.count_dbg), 32'd3);
    check("f_pre_valid", 32'(bus.Instr_Valid), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("f_rst_valid", 32'(bus.Instr_Valid), 32'd0);
    check("f_rst_refetch", 32'(bus.Refetch), 32'd0);
    check("f_rst_count", 32'(bus.count_dbg), 32'd0);
    check("f_rst_imem_en", 32'(bus.Imem_En), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    Reset_n       = 1'b1;
    bus.Address   = ADDR_W'(32'h10);
    bus.Imem_Data = '0;
    for (int i = 0; i <= 5 - LAT; i++) exp_q.push_back(ADDR_W'(32'h10 + i));
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1, 1'b0, '0);
      if (c == LAT - 1) check("f_valid_early", 32'(o_valid), 32'd0);
      if (c == LAT)     check("f_resume_pc", 32'(o_pc), 32'h10);
    end
    check("f_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
